// File: rtl/dma_write_splitter_pkg.sv
// Shared constants, FSM state type and payload-alignment helpers for the DMA write splitter.
package dma_write_splitter_pkg;

  localparam int CHUNK_W    = 32;
  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } split_state_t;

  function automatic logic [CHUNK_W-1:0] align_len(input logic [CHUNK_W-1:0] len);
    return {len[CHUNK_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
  endfunction

  function automatic logic [63:0] align_addr(input logic [63:0] addr);
    return {addr[63:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/dma_write_splitter_if.sv
// Command stream (address/length) and 512-bit data stream interfaces with master/slave views.
interface axis_mem_cmd_if;
  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;

  modport master (output valid, output address, output length, input ready);
  modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream_if;
  logic         valid;
  logic         ready;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/dma_write_splitter_chunk_calc.sv
// Chunk length = min(remaining, MAX_CHUNK, distance to next BOUNDARY-aligned address).
module dma_chunk_calc
  import dma_write_splitter_pkg::*;
#(
  parameter int MAX_CHUNK = 4096,
  parameter int BOUNDARY  = 4096
) (
  input  logic [CHUNK_W-1:0] i_addr_lo,
  input  logic [CHUNK_W-1:0] i_remaining,
  output logic [CHUNK_W-1:0] o_chunk
);

  localparam logic [CHUNK_W-1:0] LP_MAX = CHUNK_W'(MAX_CHUNK);
  localparam logic [CHUNK_W-1:0] LP_BND = CHUNK_W'(BOUNDARY);

  logic [CHUNK_W-1:0] w_offset;
  logic [CHUNK_W-1:0] w_bnd_rem;
  logic [CHUNK_W-1:0] w_limit;

  // BOUNDARY is a power of two, so the low address bits give the offset inside the window.
  assign w_offset  = i_addr_lo & (LP_BND - 32'd1);
  assign w_bnd_rem = LP_BND - w_offset;
  assign w_limit   = (LP_MAX < w_bnd_rem) ? LP_MAX : w_bnd_rem;
  assign o_chunk   = (i_remaining < w_limit) ? i_remaining : w_limit;

endmodule

// File: rtl/dma_write_splitter.sv
// Splits each DMA write command into boundary-safe chunk commands and forwards the data
// beats of each chunk with a regenerated last flag.
module dma_write_splitter
  import dma_write_splitter_pkg::*;
#(
  parameter int MAX_CHUNK = 4096,
  parameter int BOUNDARY  = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  axis_mem_cmd_if.slave        s_axis_cmd,
  axi_stream_if.slave          s_axis_data,
  axis_mem_cmd_if.master       m_axis_cmd,
  axi_stream_if.master         m_axis_data,
  output logic [2:0][31:0]     status_reg
);

  split_state_t       r_state;
  split_state_t       w_next_state;
  logic [63:0]        r_cur_addr;
  logic [CHUNK_W-1:0] r_remaining;
  logic [CHUNK_W-1:0] r_chunk_beats;
  logic [CHUNK_W-1:0] r_beat_cnt;
  logic [31:0]        r_cnt_cmd;
  logic [31:0]        r_cnt_chunk;
  logic [31:0]        r_cnt_beat;

  logic [CHUNK_W-1:0] w_chunk;
  logic [CHUNK_W-1:0] w_in_len;
  logic               w_last_beat;
  logic               w_cmd_acc;
  logic               w_chunk_hs;
  logic               w_beat_hs;

  dma_chunk_calc #(
    .MAX_CHUNK (MAX_CHUNK),
    .BOUNDARY  (BOUNDARY)
  ) u_chunk_calc (
    .i_addr_lo   (r_cur_addr[CHUNK_W-1:0]),
    .i_remaining (r_remaining),
    .o_chunk     (w_chunk)
  );

  assign w_in_len    = align_len(s_axis_cmd.length);
  assign w_last_beat = (r_beat_cnt == (r_chunk_beats - 32'd1));

  assign m_axis_cmd.address = r_cur_addr;
  assign m_axis_cmd.length  = w_chunk;
  assign m_axis_data.data   = s_axis_data.data;
  assign m_axis_data.keep   = s_axis_data.keep;

  assign status_reg[0] = r_cnt_cmd;
  assign status_reg[1] = r_cnt_chunk;
  assign status_reg[2] = r_cnt_beat;

  always_comb begin
    w_next_state       = r_state;
    w_cmd_acc          = 1'b0;
    w_chunk_hs         = 1'b0;
    w_beat_hs          = 1'b0;
    s_axis_cmd.ready   = 1'b0;
    m_axis_cmd.valid   = 1'b0;
    m_axis_data.valid  = 1'b0;
    m_axis_data.last   = 1'b0;
    s_axis_data.ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ready is held low while reset is asserted so nothing is offered as accepted.
        s_axis_cmd.ready = rstn;
        if (s_axis_cmd.valid && rstn) begin
          w_cmd_acc = 1'b1;
          if (w_in_len[CHUNK_W-1:BEAT_SHIFT] != '0) begin
            w_next_state = ST_CMD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CMD: begin
        m_axis_cmd.valid = 1'b1;
        if (m_axis_cmd.ready) begin
          w_chunk_hs   = 1'b1;
          w_next_state = ST_DATA;
        end else begin
          w_next_state = ST_CMD;
        end
      end
      ST_DATA: begin
        m_axis_data.valid = s_axis_data.valid;
        s_axis_data.ready = m_axis_data.ready;
        m_axis_data.last  = w_last_beat;
        if (s_axis_data.valid && m_axis_data.ready) begin
          w_beat_hs = 1'b1;
          if (w_last_beat) begin
            w_next_state = (r_remaining != '0) ? ST_CMD : ST_IDLE;
          end else begin
            w_next_state = ST_DATA;
          end
        end else begin
          w_next_state = ST_DATA;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= 64'd0;
      r_remaining   <= 32'd0;
      r_chunk_beats <= 32'd0;
      r_beat_cnt    <= 32'd0;
      r_cnt_cmd     <= 32'd0;
      r_cnt_chunk   <= 32'd0;
      r_cnt_beat    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_cmd_acc) begin
        r_cur_addr  <= align_addr(s_axis_cmd.address);
        r_remaining <= w_in_len;
        r_cnt_cmd   <= r_cnt_cmd + 32'd1;
      end
      if (w_chunk_hs) begin
        r_chunk_beats <= w_chunk >> BEAT_SHIFT;
        r_beat_cnt    <= 32'd0;
        r_cur_addr    <= r_cur_addr + {32'd0, w_chunk};
        r_remaining   <= r_remaining - w_chunk;
        r_cnt_chunk   <= r_cnt_chunk + 32'd1;
      end
      if (w_beat_hs) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
        r_cnt_beat <= r_cnt_beat + 32'd1;
      end
    end
  end

endmodule
